// File: rtl/audioport_pkg.sv
// Shared constants and types for the audio port DSP path.
package audioport_pkg;

  // FIR length per channel; dsp_unit sizes its coefficient and delay-line
  // memories from the same constant.
  localparam int FILTER_TAPS = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    MAC   = 3'd2,
    SCALE = 3'd3,
    CAPT  = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  // Control strobes towards the datapath. The tap index and the channel
  // are carried separately because their widths and meaning differ.
  typedef struct packed {
    logic       shift;
    logic       mac_clr;
    logic       mac_en;
    logic       bypass;
    logic       scale;
    logic [1:0] cap;
    logic       tick;
    logic       busy;
  } seq_strobes_t;

  // Pure decode of the sequencer position into datapath strobes.
  function automatic seq_strobes_t decode_strobes(
    input seq_state_t st,
    input logic       tap_zero,
    input logic       chan,
    input logic       filt
  );
    seq_strobes_t s;
    s        = '0;
    s.busy   = (st != IDLE);
    s.bypass = (st != IDLE) && !filt;
    case (st)
      SHIFT: s.shift = 1'b1;
      MAC: begin
        s.mac_en  = 1'b1;
        s.mac_clr = tap_zero;
      end
      SCALE: s.scale = 1'b1;
      CAPT:  s.cap   = chan ? 2'b10 : 2'b01;
      DONE:  s.tick  = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dsp_sequencer_sva.sv
// Protocol properties of the sequencer strobes, bound into every instance.
module dsp_sequencer_sva (
  input logic       clk,
  input logic       rst_n,
  input logic       clr_in,
  input logic       shift_out,
  input logic       mac_en_out,
  input logic       scale_out,
  input logic [1:0] cap_out,
  input logic       tick_out
);

  logic [1:0] cap_cnt;

  // Count captures since the last completed or aborted run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_cnt <= '0;
    end else if (clr_in || tick_out) begin
      cap_cnt <= '0;
    end else if ((cap_out != 2'b00) && (cap_cnt != 2'd3)) begin
      cap_cnt <= cap_cnt + 2'd1;
    end
  end

  a_cap_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(cap_out));

  a_mac_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(mac_en_out && (scale_out || shift_out)));

  a_tick_after_two_caps: assert property (@(posedge clk) disable iff (!rst_n)
    tick_out |-> (cap_cnt == 2'd2));

endmodule

bind dsp_sequencer dsp_sequencer_sva u_dsp_sequencer_sva (.*);

// File: rtl/dsp_sequencer.sv
// Control sequencer for the shared MAC datapath in dsp_unit. Per sample
// tick it walks both channels through shift, FIR MAC, level scaling and
// capture, then announces the finished stereo pair with tick_out.
module dsp_sequencer #(
  parameter int FILTER_TAPS = audioport_pkg::FILTER_TAPS,
  parameter int TAP_W       = $clog2(FILTER_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             clr_in,
  input  logic             filter_in,
  output logic             shift_out,
  output logic [TAP_W-1:0] tap_addr_out,
  output logic             chan_out,
  output logic             mac_clr_out,
  output logic             mac_en_out,
  output logic             bypass_out,
  output logic             scale_out,
  output logic [1:0]       cap_out,
  output logic             tick_out,
  output logic             busy_out,
  output logic             overrun_out
);

  import audioport_pkg::*;

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(FILTER_TAPS - 1);

  seq_state_t       state_r, state_nxt;
  logic [TAP_W-1:0] tap_r, tap_nxt;
  logic             chan_r, chan_nxt;
  logic             filt_r, filt_nxt;
  logic             overrun_r, overrun_nxt;
  seq_strobes_t     strb_r, strb_nxt;

  // Next-state logic; strobes are decoded from the next position so that
  // the registered outputs line up with the state they describe.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_nxt   = state_r;
    tap_nxt     = tap_r;
    chan_nxt    = chan_r;
    filt_nxt    = filt_r;
    overrun_nxt = 1'b0;

    if (clr_in) begin
      state_nxt = IDLE;
      tap_nxt   = '0;
      chan_nxt  = 1'b0;
      filt_nxt  = 1'b0;
    end else begin
      // A tick arriving while a run is in flight is dropped and flagged.
      overrun_nxt = tick_in && (state_r != IDLE);

      case (state_r)
        IDLE: begin
          if (tick_in) begin
            state_nxt = SHIFT;
            filt_nxt  = filter_in;
            chan_nxt  = 1'b0;
            tap_nxt   = '0;
          end
        end
        SHIFT: begin
          chan_nxt  = 1'b0;
          state_nxt = filt_r ? MAC : SCALE;
        end
        MAC: begin
          if (tap_r == LAST_TAP) begin
            tap_nxt   = '0;
            state_nxt = SCALE;
          end else begin
            tap_nxt = tap_r + TAP_W'(1);
          end
        end
        SCALE: state_nxt = CAPT;
        CAPT: begin
          if (!chan_r) begin
            chan_nxt  = 1'b1;
            state_nxt = filt_r ? MAC : SCALE;
          end else begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          chan_nxt  = 1'b0;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          tap_nxt   = '0;
          chan_nxt  = 1'b0;
        end
      endcase
    end

    strb_nxt = decode_strobes(state_nxt, (tap_nxt == '0), chan_nxt, filt_nxt);
  end

  // Position and output registers; asynchronous reset keeps every strobe
  // low from the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      tap_r     <= '0;
      chan_r    <= 1'b0;
      filt_r    <= 1'b0;
      overrun_r <= 1'b0;
      strb_r    <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register see the values
      // from before this edge, independent of statement order.
      state_r   <= state_nxt;
      tap_r     <= tap_nxt;
      chan_r    <= chan_nxt;
      filt_r    <= filt_nxt;
      overrun_r <= overrun_nxt;
      strb_r    <= strb_nxt;
    end
  end

  assign shift_out    = strb_r.shift;
  assign tap_addr_out = tap_r;
  assign chan_out     = chan_r;
  assign mac_clr_out  = strb_r.mac_clr;
  assign mac_en_out   = strb_r.mac_en;
  assign bypass_out   = strb_r.bypass;
  assign scale_out    = strb_r.scale;
  assign cap_out      = strb_r.cap;
  assign tick_out     = strb_r.tick;
  assign busy_out     = strb_r.busy;
  assign overrun_out  = overrun_r;

endmodule

// File: tb/tb_dsp_sequencer.sv
// Scoreboard bench for dsp_sequencer: each accepted tick pushes the full
// expected strobe schedule; a negedge monitor pops one entry every cycle
// the DUT drives any output high.
module tb_dsp_sequencer;

  localparam int FT  = 32;
  localparam int TW  = $clog2(FT);
  localparam int VW  = 11 + TW;
  localparam int BIG = 1000000;

  typedef logic [VW-1:0] vec_t;
  typedef struct {
    int   cyc;
    vec_t vec;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          tick_in;
  logic          clr_in;
  logic          filter_in;
  logic          shift_out;
  logic [TW-1:0] tap_addr_out;
  logic          chan_out;
  logic          mac_clr_out;
  logic          mac_en_out;
  logic          bypass_out;
  logic          scale_out;
  logic [1:0]    cap_out;
  logic          tick_out;
  logic          busy_out;
  logic          overrun_out;

  int   cyc;
  int   checks;
  int   errors;
  int   last_tick;
  exp_t exp_q[$];
  vec_t mon_v;
  exp_t mon_e;

  dsp_sequencer #(.FILTER_TAPS(FT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_in      (tick_in),
    .clr_in       (clr_in),
    .filter_in    (filter_in),
    .shift_out    (shift_out),
    .tap_addr_out (tap_addr_out),
    .chan_out     (chan_out),
    .mac_clr_out  (mac_clr_out),
    .mac_en_out   (mac_en_out),
    .bypass_out   (bypass_out),
    .scale_out    (scale_out),
    .cap_out      (cap_out),
    .tick_out     (tick_out),
    .busy_out     (busy_out),
    .overrun_out  (overrun_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t dut_vec();
    return {shift_out, mac_clr_out, mac_en_out, bypass_out, scale_out, cap_out,
            tick_out, busy_out, overrun_out, chan_out, tap_addr_out};
  endfunction

  // Expected vector of a busy cycle; overrun is patched in by push_ev.
  function automatic vec_t mk(bit shift, bit mclr, bit men, bit byp, bit scl,
                              logic [1:0] cap, bit tick, bit chan, int tap);
    return {shift, mclr, men, byp, scl, cap, tick, 1'b1, 1'b0, chan, TW'(tap)};
  endfunction

  task automatic push_ev(input int c, input vec_t v, input int ovr_c, input int stop_c);
    exp_t e;
    if (c > stop_c) return;
    e.cyc = c;
    e.vec = v;
    if (c == ovr_c) e.vec[TW+1] = 1'b1;
    exp_q.push_back(e);
  endtask

  // Schedule of one run starting with tick_in in cycle t0.
  task automatic push_run(input int t0, input bit filt, input int ovr_off, input int stop_off);
    int c;
    int oc;
    int sc;
    bit byp;
    byp = !filt;
    oc  = t0 + ovr_off;
    sc  = t0 + stop_off;
    c   = t0 + 1;
    push_ev(c, mk(1, 0, 0, byp, 0, 2'b00, 0, 0, 0), oc, sc);
    for (int ch = 0; ch < 2; ch++) begin
      if (filt) begin
        for (int k = 0; k < FT; k++) begin
          c++;
          push_ev(c, mk(0, k == 0, 1, byp, 0, 2'b00, 0, ch[0], k), oc, sc);
        end
      end
      c++;
      push_ev(c, mk(0, 0, 0, byp, 1, 2'b00, 0, ch[0], 0), oc, sc);
      c++;
      push_ev(c, mk(0, 0, 0, byp, 0, ch[0] ? 2'b10 : 2'b01, 0, ch[0], 0), oc, sc);
    end
    c++;
    push_ev(c, mk(0, 0, 0, byp, 0, 2'b00, 1, 1, 0), oc, sc);
  endtask

  // Advance to #1 after the posedge that starts cycle c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_tick(input bit filt, input int ovr_off, input int stop_off,
                            output int t0);
    @(posedge clk);
    #1;
    t0        = cyc;
    tick_in   = 1'b1;
    filter_in = filt;
    push_run(t0, filt, ovr_off, stop_off);
    @(posedge clk);
    #1;
    tick_in   = 1'b0;
    filter_in = !filt;
  endtask

  // Monitor: every cycle with any output high must match the queue head.
  always @(negedge clk) begin
    mon_v = dut_vec();
    if (mon_v != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", longint'(mon_v), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_cycle", cyc, mon_e.cyc);
        check("event_outputs", longint'(mon_v), longint'(mon_e.vec));
      end
      if (tick_out) last_tick = cyc;
    end
  end

  initial begin
    int t0;
    int t1;
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    last_tick = -1;
    rst_n     = 1'b0;
    tick_in   = 1'b0;
    clr_in    = 1'b0;
    filter_in = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    repeat (10) begin
      @(negedge clk);
      check("idle_outputs", longint'(dut_vec()), 0);
    end

    // Filter run; filter_in flips right after the tick and must be ignored.
    start_tick(1'b1, -BIG, BIG, t0);
    goto(t0 + 74);
    check("filter_tick_cycle", last_tick, t0 + 70);

    // Bypass run.
    start_tick(1'b0, -BIG, BIG, t0);
    goto(t0 + 10);
    check("bypass_tick_cycle", last_tick, t0 + 6);

    // Tick during MAC at cycle 20: overrun at 21, run undisturbed.
    start_tick(1'b1, 21, BIG, t0);
    goto(t0 + 20);
    tick_in = 1'b1;
    goto(t0 + 21);
    tick_in = 1'b0;
    goto(t0 + 80);
    check("overrun_tick_cycle", last_tick, t0 + 70);

    // Clear at cycle 40, then a fresh run from cycle 45.
    start_tick(1'b1, -BIG, 40, t0);
    goto(t0 + 40);
    clr_in = 1'b1;
    goto(t0 + 41);
    clr_in = 1'b0;
    @(negedge clk);
    check("clr_outputs", longint'(dut_vec()), 0);
    goto(t0 + 44);
    start_tick(1'b1, -BIG, BIG, t1);
    check("restart_cycle", t1, t0 + 45);
    goto(t0 + 120);
    check("restart_tick_cycle", last_tick, t0 + 115);

    // tick_in together with clr_in in IDLE: nothing starts, no overrun.
    @(posedge clk);
    #1;
    tick_in = 1'b1;
    clr_in  = 1'b1;
    @(posedge clk);
    #1;
    tick_in = 1'b0;
    clr_in  = 1'b0;
    @(negedge clk);
    check("tick_clr_busy", busy_out, 0);
    check("tick_clr_overrun", overrun_out, 0);
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of the MAC phase.
    start_tick(1'b1, -BIG, 10, t0);
    goto(t0 + 10);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", longint'(dut_vec()), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle", longint'(dut_vec()), 0);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
